// File: rtl/prng_stream_if.sv
// Valid/ready word stream carrying buffered PRNG output from prng_stream
// to its consumer.
interface prng_stream_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/prng_stream.sv
// Sequencer and output FIFO for an external registered PRNG: reseeds it,
// discards warm-up steps, then streams fresh words over valid/ready.

module prng_stream_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          push,
  input logic          flush,
  input logic [CW-1:0] count
);
  // The in-flight limit must never let a push land on a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst && push && !flush) begin
      assert (count != CW'(DEPTH));
    end
  end
endmodule

module prng_stream #(
  parameter int               WIDTH        = 8,
  parameter int               DEPTH        = 4,
  parameter int               DISCARD      = 2,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(8'hA5),
  localparam int              CW           = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             seed_load,
  output logic             prng_update,
  output logic             prng_reseed,
  output logic [WIDTH-1:0] prng_seed,
  input  logic [WIDTH-1:0] prng_rand,
  prng_stream_if.master    out,
  output logic [CW-1:0]    count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = (DISCARD > 1) ? $clog2(DISCARD) : 1;

  typedef enum logic [1:0] {
    ST_SEED = 2'd0,
    ST_WARM = 2'd1,
    ST_FILL = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             boot_q, boot_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WW-1:0]    warm_q, warm_d;
  logic             inflight_q, inflight_d;
  logic             update_q, update_d;
  logic             reseed_q, reseed_d;
  logic [WIDTH-1:0] prng_seed_q, prng_seed_d;
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic valid_s, pop_s, push_s, restart_s;

  // boot_q forces one SEED cycle right after reset, sharing the seed_load path.
  assign restart_s = seed_load || boot_q;
  assign valid_s   = (count_q != '0);
  assign pop_s     = valid_s && out.ready;
  assign push_s    = inflight_q;

  // Sequencer next state and next values of the registered PRNG controls.
  always_comb begin
    state_d    = state_q;
    warm_d     = warm_q;
    boot_d     = 1'b0;
    seed_d     = seed_q;
    inflight_d = 1'b0;
    update_d   = 1'b0;

    if (seed_load) begin
      seed_d = seed_in;
    end else begin
      seed_d = seed_q;
    end

    if (restart_s) begin
      state_d = ST_SEED;
    end else begin
      case (state_q)
        ST_SEED: begin
          if (DISCARD > 0) begin
            state_d = ST_WARM;
            warm_d  = WW'(DISCARD - 1);
          end else begin
            state_d = ST_FILL;
          end
        end
        ST_WARM: begin
          if (warm_q == '0) begin
            state_d = ST_FILL;
          end else begin
            warm_d = warm_q - WW'(1);
          end
        end
        ST_FILL: state_d = ST_FILL;
        default: state_d = ST_SEED;
      endcase
    end

    // Only FILL steps produce a word worth pushing one cycle later.
    inflight_d = update_q && (state_q == ST_FILL) && !restart_s;

    case (state_d)
      ST_WARM: update_d = 1'b1;
      ST_FILL: update_d = (({1'b0, count_d} + {{CW{1'b0}}, inflight_d}) < (CW + 1)'(DEPTH));
      default: update_d = 1'b0;
    endcase

    reseed_d = (state_d == ST_SEED);
    if (reseed_d) begin
      prng_seed_d = seed_d;
    end else begin
      prng_seed_d = prng_seed_q;
    end
  end

  // FIFO pointer and occupancy next values; a restart flushes everything.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (restart_s) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push_s) begin
        wr_d = wr_q + PW'(1);
      end else begin
        wr_d = wr_q;
      end
      if (pop_s) begin
        rd_d = rd_q + PW'(1);
      end else begin
        rd_d = rd_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Sequencer state and registered PRNG control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SEED;
      boot_q      <= 1'b1;
      seed_q      <= SEED_DEFAULT;
      warm_q      <= '0;
      inflight_q  <= 1'b0;
      update_q    <= 1'b0;
      reseed_q    <= 1'b0;
      prng_seed_q <= '0;
    end else begin
      state_q     <= state_d;
      boot_q      <= boot_d;
      seed_q      <= seed_d;
      warm_q      <= warm_d;
      inflight_q  <= inflight_d;
      update_q    <= update_d;
      reseed_q    <= reseed_d;
      prng_seed_q <= prng_seed_d;
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      if (push_s && !restart_s) begin
        mem_q[wr_q] <= prng_rand;
      end
    end
  end

  assign prng_update = update_q;
  assign prng_reseed = reseed_q;
  assign prng_seed   = prng_seed_q;
  assign out.data    = mem_q[rd_q];
  assign out.valid   = valid_s;
  assign count       = count_q;

  prng_stream_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .flush (restart_s),
    .count (count_q)
  );
endmodule

// File: tb/tb_prng_stream.sv
// Directed bench for prng_stream: two instances (DISCARD=2 and DISCARD=0)
// each driving a registered 8-step Galois LFSR model.
module tb_prng_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       seed_load;
  logic [7:0] seed_in;
  logic       out_ready;

  logic       upd_a, rsd_a, upd_b, rsd_b;
  logic [7:0] sd_a, sd_b, rand_a, rand_b;
  logic [2:0] cnt_a, cnt_b;
  logic [7:0] st_a = 8'h00;
  logic [7:0] st_b = 8'h00;

  int n_pass  = 0;
  int n_total = 0;

  prng_stream_if #(.WIDTH(8)) sif_a ();
  prng_stream_if #(.WIDTH(8)) sif_b ();
  assign sif_a.ready = out_ready;
  assign sif_b.ready = out_ready;

  prng_stream #(.WIDTH(8), .DEPTH(4), .DISCARD(2), .SEED_DEFAULT(8'hA5)) dut_a (
    .clk(clk), .rst(rst), .seed_in(seed_in), .seed_load(seed_load),
    .prng_update(upd_a), .prng_reseed(rsd_a), .prng_seed(sd_a), .prng_rand(rand_a),
    .out(sif_a), .count(cnt_a)
  );

  prng_stream #(.WIDTH(8), .DEPTH(4), .DISCARD(0), .SEED_DEFAULT(8'hA5)) dut_b (
    .clk(clk), .rst(rst), .seed_in(seed_in), .seed_load(seed_load),
    .prng_update(upd_b), .prng_reseed(rsd_b), .prng_seed(sd_b), .prng_rand(rand_b),
    .out(sif_b), .count(cnt_b)
  );

  function automatic logic [7:0] step8(input logic [7:0] x);
    logic [7:0] v;
    v = x;
    for (int i = 0; i < 8; i++) begin
      v = v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    end
    return v;
  endfunction

  function automatic logic [7:0] nth(input logic [7:0] s, input int n);
    logic [7:0] v;
    v = s;
    for (int i = 0; i < n; i++) begin
      v = step8(v);
    end
    return v;
  endfunction

  // PRNG models: reseed loads, update steps, output is the register.
  always @(posedge clk) begin
    if (rsd_a) st_a <= sd_a;
    else if (upd_a) st_a <= step8(st_a);
    if (rsd_b) st_b <= sd_b;
    else if (upd_b) st_b <= step8(st_b);
  end
  assign rand_a = st_a;
  assign rand_b = st_b;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic reset_check();
    chk("rst_valid",  32'(sif_a.valid), 32'd0);
    chk("rst_data",   32'(sif_a.data),  32'd0);
    chk("rst_count",  32'(cnt_a),       32'd0);
    chk("rst_update", 32'(upd_a),       32'd0);
    chk("rst_reseed", 32'(rsd_a),       32'd0);
    chk("rst_seed",   32'(sd_a),        32'd0);
  endtask

  // Entered one cycle before the SEED cycle; ends in cycle 10 after it.
  task automatic boot_check(input logic [7:0] seed, input bit chk_b);
    cyc();
    seed_load = 1'b0;
    out_ready = 1'b1;
    chk("seed_reseed", 32'(rsd_a),       32'd1);
    chk("seed_value",  32'(sd_a),        32'(seed));
    chk("seed_count",  32'(cnt_a),       32'd0);
    chk("seed_valid",  32'(sif_a.valid), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      chk("warm_update", 32'(upd_a),       32'd1);
      chk("warm_valid",  32'(sif_a.valid), 32'd0);
      chk("warm_count",  32'(cnt_a),       32'd0);
      if (c == 1) chk("warm_reseed_low", 32'(rsd_a), 32'd0);
      if (chk_b && c == 2) chk("d0_valid_low", 32'(sif_b.valid), 32'd0);
      if (chk_b && c == 3) begin
        chk("d0_valid_high", 32'(sif_b.valid), 32'd1);
        chk("d0_first_word", 32'(sif_b.data),  32'(nth(seed, 1)));
      end
      if (chk_b && c == 4) chk("d0_second_word", 32'(sif_b.data), 32'(nth(seed, 2)));
    end
    // out_valid rose at the close of cycle 4: words are steps 3,4,5,...
    for (int j = 0; j < 6; j++) begin
      cyc();
      chk("stream_valid", 32'(sif_a.valid), 32'd1);
      chk("stream_data",  32'(sif_a.data),  32'(nth(seed, 3 + j)));
      chk("stream_count", 32'(cnt_a),       32'd1);
    end
  endtask

  initial begin
    bit found;
    rst       = 1'b1;
    seed_load = 1'b0;
    seed_in   = 8'h00;
    out_ready = 1'b1;
    cyc();
    cyc();
    reset_check();

    // Reset release with a consumer always ready.
    rst = 1'b0;
    boot_check(8'hA5, 1'b1);

    // Consumer stalled from reset: FIFO fills, then drains without gaps.
    rst       = 1'b1;
    out_ready = 1'b0;
    cyc();
    reset_check();
    rst = 1'b0;
    cyc();
    for (int c = 1; c <= 10; c++) begin
      cyc();
      if (c == 7) chk("full_update_stop", 32'(upd_a), 32'd0);
      if (c >= 8) begin
        chk("full_count",  32'(cnt_a),       32'd4);
        chk("full_update", 32'(upd_a),       32'd0);
        chk("full_valid",  32'(sif_a.valid), 32'd1);
        chk("full_data",   32'(sif_a.data),  32'(nth(8'hA5, 3)));
      end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_valid", 32'(sif_a.valid), 32'd1);
      chk("drain_data",  32'(sif_a.data),  32'(nth(8'hA5, 3 + k)));
      if (k == 1) chk("resume_update", 32'(upd_a), 32'd1);
      cyc();
    end

    // Reseed with 3C while stalled at count 3.
    out_ready = 1'b0;
    found     = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (cnt_a == 3'd3) found = 1'b1;
      else cyc();
    end
    chk("count3_reached", 32'(found), 32'd1);
    seed_in   = 8'h3C;
    seed_load = 1'b1;
    boot_check(8'h3C, 1'b0);

    // Reseed coincident with a completing handshake.
    chk("hs_valid", 32'(sif_a.valid), 32'd1);
    chk("hs_data",  32'(sif_a.data),  32'(nth(8'h3C, 8)));
    seed_in   = 8'h96;
    seed_load = 1'b1;
    boot_check(8'h96, 1'b0);

    // Back-to-back reseeds: 5A then C3.
    seed_in   = 8'h5A;
    seed_load = 1'b1;
    cyc();
    chk("b2b_reseed1", 32'(rsd_a), 32'd1);
    chk("b2b_seed1",   32'(sd_a),  32'h5A);
    chk("b2b_count1",  32'(cnt_a), 32'd0);
    seed_in = 8'hC3;
    boot_check(8'hC3, 1'b0);

    // Reset mid-stream with the FIFO half full.
    out_ready = 1'b0;
    found     = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (cnt_a == 3'd2) found = 1'b1;
      else cyc();
    end
    chk("half_full_reached", 32'(found), 32'd1);
    rst = 1'b1;
    cyc();
    reset_check();
    rst = 1'b0;
    boot_check(8'hA5, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
